// File: rtl/uncached_dbus_bridge.sv
// rtl/uncached_dbus_bridge.sv - uncached data-bus to cbus single-beat bridge
//
// Purpose: responder for translated CPU data requests that target uncached
// space. One accepted request becomes one single-beat cbus transaction; the
// result is returned to the pipeline as a one-cycle data_ok pulse.
//
// Optional feature macro: UNCACHED_TIMEOUT_EN
//   defined   -> watchdog on the BUS state, TIMEOUT_CYCLES parameter and the
//                timeout_err_o output port exist
//   undefined -> BUS waits for cbus completion indefinitely
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   dreq_*_i, uncached_i  translated data request; accepted when valid && uncached in IDLE
//   dresp_*_o             addr_ok (combinational in IDLE), data_ok/data (DONE cycle)
//   creq_*_o              request to cbus arbiter, stable while creq_valid_o
//   cresp_*_i             cbus response (ready, last, data)
//   busy_o                high whenever not IDLE
//   acc_count_o           completed transactions, wraps at 2^CNT_W
//   timeout_err_o         (UNCACHED_TIMEOUT_EN only) pulse with a forced error reply
//
// Encodings: size MSIZE1=0, MSIZE2=1, MSIZE4=2; len MLEN1=0; burst FIXED=0.

module uncached_dbus_bridge #(
`ifdef UNCACHED_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,

    input  logic             dreq_valid_i,
    input  logic [31:0]      dreq_addr_i,
    input  logic [2:0]       dreq_size_i,
    input  logic [3:0]       dreq_strobe_i,
    input  logic [31:0]      dreq_data_i,
    input  logic             uncached_i,

    output logic             dresp_addr_ok_o,
    output logic             dresp_data_ok_o,
    output logic [31:0]      dresp_data_o,

    output logic             creq_valid_o,
    output logic             creq_is_write_o,
    output logic [31:0]      creq_addr_o,
    output logic [2:0]       creq_size_o,
    output logic [3:0]       creq_strobe_o,
    output logic [31:0]      creq_data_o,
    output logic [3:0]       creq_len_o,
    output logic [1:0]       creq_burst_o,

    input  logic             cresp_ready_i,
    input  logic             cresp_last_i,
    input  logic [31:0]      cresp_data_i,

    output logic             busy_o,
    output logic [CNT_W-1:0] acc_count_o
`ifdef UNCACHED_TIMEOUT_EN
    ,
    output logic             timeout_err_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0]  MLEN1           = 4'd0;
    localparam logic [1:0]  AXI_BURST_FIXED = 2'd0;
    localparam logic [31:0] TIMEOUT_DATA    = 32'hDEAD_BEEF;

    logic [1:0]       state_q,  state_d;
    logic [31:0]      addr_q,   addr_d;
    logic [2:0]       size_q,   size_d;
    logic [3:0]       strobe_q, strobe_d;
    logic [31:0]      wdata_q,  wdata_d;
    logic [31:0]      rdata_q,  rdata_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic handshake;
    logic in_bus;
    logic in_done;
    logic bus_complete;

`ifdef UNCACHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
`endif

    assign in_bus       = (state_q == ST_BUS);
    assign in_done      = (state_q == ST_DONE);
    assign handshake    = (state_q == ST_IDLE) && dreq_valid_i && uncached_i;
    assign bus_complete = cresp_ready_i && cresp_last_i;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
`ifdef UNCACHED_TIMEOUT_EN
        wd_d     = wd_q;
        to_d     = to_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    addr_d   = dreq_addr_i;
                    size_d   = dreq_size_i;
                    strobe_d = dreq_strobe_i;
                    wdata_d  = dreq_data_i;
                    rdata_d  = '0;
                    state_d  = ST_BUS;
`ifdef UNCACHED_TIMEOUT_EN
                    wd_d     = '0;
                    to_d     = 1'b0;
`endif
                end
            end
            ST_BUS: begin
                // Any ready beat refreshes the captured data; only the
                // final (last) beat ends the transaction.
                if (cresp_ready_i) begin
                    rdata_d = cresp_data_i;
                end
                if (bus_complete) begin
                    state_d = ST_DONE;
                end
`ifdef UNCACHED_TIMEOUT_EN
                // Completion on the limit cycle takes priority over abandon.
                else if (wd_q == WD_LAST) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
`ifdef UNCACHED_TIMEOUT_EN
            wd_q     <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
`ifdef UNCACHED_TIMEOUT_EN
            wd_q     <= wd_d;
            to_q     <= to_d;
`endif
        end
    end

    // creq fields are forced to zero outside BUS so the bus sees a clean
    // idle request; inside BUS they come straight from the latched copy.
    assign creq_valid_o    = in_bus;
    assign creq_is_write_o = in_bus && (|strobe_q);
    assign creq_addr_o     = in_bus ? addr_q   : '0;
    assign creq_size_o     = in_bus ? size_q   : '0;
    assign creq_strobe_o   = in_bus ? strobe_q : '0;
    assign creq_data_o     = in_bus ? wdata_q  : '0;
    assign creq_len_o      = MLEN1;
    assign creq_burst_o    = AXI_BURST_FIXED;

    assign dresp_addr_ok_o = handshake;
    assign dresp_data_ok_o = in_done;

`ifdef UNCACHED_TIMEOUT_EN
    assign timeout_err_o = in_done && to_q;
    assign dresp_data_o  = !in_done     ? 32'd0 :
                           to_q         ? TIMEOUT_DATA :
                           (|strobe_q)  ? 32'd0 : rdata_q;
`else
    assign dresp_data_o  = (in_done && !(|strobe_q)) ? rdata_q : 32'd0;
`endif

    assign busy_o      = (state_q != ST_IDLE);
    assign acc_count_o = cnt_q;

endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// tb/tb_uncached_dbus_bridge.sv - self-checking bench for uncached_dbus_bridge
module tb_uncached_dbus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        dreq_valid, uncached;
    logic [31:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic        addr_ok, data_ok;
    logic [31:0] rdata_o;
    logic        creq_valid, creq_is_write;
    logic [31:0] creq_addr, creq_data;
    logic [2:0]  creq_size;
    logic [3:0]  creq_strobe, creq_len;
    logic [1:0]  creq_burst;
    logic        cresp_ready, cresp_last;
    logic [31:0] cresp_data;
    logic        busy;
    logic [1:0]  acc_count;
`ifdef UNCACHED_TIMEOUT_EN
    logic        timeout_err;
`endif

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    uncached_dbus_bridge #(
`ifdef UNCACHED_TIMEOUT_EN
        .TIMEOUT_CYCLES(8),
`endif
        .CNT_W(2)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .dreq_valid_i(dreq_valid), .dreq_addr_i(dreq_addr), .dreq_size_i(dreq_size),
        .dreq_strobe_i(dreq_strobe), .dreq_data_i(dreq_data), .uncached_i(uncached),
        .dresp_addr_ok_o(addr_ok), .dresp_data_ok_o(data_ok), .dresp_data_o(rdata_o),
        .creq_valid_o(creq_valid), .creq_is_write_o(creq_is_write), .creq_addr_o(creq_addr),
        .creq_size_o(creq_size), .creq_strobe_o(creq_strobe), .creq_data_o(creq_data),
        .creq_len_o(creq_len), .creq_burst_o(creq_burst),
        .cresp_ready_i(cresp_ready), .cresp_last_i(cresp_last), .cresp_data_i(cresp_data),
        .busy_o(busy), .acc_count_o(acc_count)
`ifdef UNCACHED_TIMEOUT_EN
        , .timeout_err_o(timeout_err)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        pre;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] a, input logic [2:0] s,
                           input logic [3:0] st, input logic [31:0] d);
        dreq_valid  = 1'b1;
        uncached    = 1'b1;
        dreq_addr   = a;
        dreq_size   = s;
        dreq_strobe = st;
        dreq_data   = d;
    endtask

    task automatic bus_idle();
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = 32'h0;
    endtask

    task automatic chk_creq(input string nm, input vec_t v);
        chk({nm, "_valid"},  32'(creq_valid), 32'd1);
        chk({nm, "_iswr"},   32'(creq_is_write), 32'(|v.strobe));
        chk({nm, "_addr"},   creq_addr, v.addr);
        chk({nm, "_size"},   32'(creq_size), 32'(v.size));
        chk({nm, "_strobe"}, 32'(creq_strobe), 32'(v.strobe));
        chk({nm, "_data"},   creq_data, v.wdata);
        chk({nm, "_len"},    32'(creq_len), 32'd0);
        chk({nm, "_burst"},  32'(creq_burst), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h1FD0_03F8, 3'd2, 4'b0000, 32'h0,         32'h1234_5678, 2, 1'b0, 32'h1234_5678};
        vecs[1] = '{32'h1FAF_0000, 3'd2, 4'b0011, 32'hAABB_CCDD, 32'h5555_5555, 3, 1'b0, 32'h0};
        vecs[2] = '{32'h1FC0_0001, 3'd0, 4'b0000, 32'h0,         32'h0000_00A5, 0, 1'b0, 32'h0000_00A5};
        vecs[3] = '{32'h1FD0_0100, 3'd2, 4'b0000, 32'h0,         32'hCAFE_F00D, 2, 1'b1, 32'hCAFE_F00D};
        vecs[4] = '{32'h1FB0_0010, 3'd2, 4'b1111, 32'h0102_0304, 32'h7777_7777, 1, 1'b0, 32'h0};

        reset = 1'b1;
        dreq_valid = 1'b0; uncached = 1'b0;
        dreq_addr = 32'h0; dreq_size = 3'd0; dreq_strobe = 4'h0; dreq_data = 32'h0;
        bus_idle();
        @(negedge clk); #1;
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_cvalid", 32'(creq_valid), 32'd0);
        chk("rst_caddr",  creq_addr, 32'd0);
        chk("rst_dataok", 32'(data_ok), 32'd0);
        chk("rst_addrok", 32'(addr_ok), 32'd0);
        chk("rst_cnt",    32'(acc_count), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();

        // table-driven single transactions; counter wraps with CNT_W=2
        for (int i = 0; i < 5; i++) begin
            present(vecs[i].addr, vecs[i].size, vecs[i].strobe, vecs[i].wdata);
            #1;
            chk($sformatf("v%0d_addrok", i), 32'(addr_ok), 32'd1);
            chk($sformatf("v%0d_idlebusy", i), 32'(busy), 32'd0);
            cyc();
            dreq_valid = 1'b0;
            dreq_addr  = ~vecs[i].addr;
            dreq_data  = 32'hFFFF_0000;
            bus_idle();
            #1;
            chk_creq($sformatf("v%0d_bus", i), vecs[i]);
            chk($sformatf("v%0d_busaddrok", i), 32'(addr_ok), 32'd0);
            for (int w = 0; w < vecs[i].waits; w++) begin
                cresp_ready = vecs[i].pre && (w == 0);
                cresp_last  = 1'b0;
                cresp_data  = 32'h0BAD_0000 | 32'(w);
                #1;
                chk_creq($sformatf("v%0d_wait%0d", i, w), vecs[i]);
                cyc();
            end
            cresp_ready = 1'b1;
            cresp_last  = 1'b1;
            cresp_data  = vecs[i].rdata;
            #1;
            chk_creq($sformatf("v%0d_last", i), vecs[i]);
            cyc();
            bus_idle();
            #1;
            chk($sformatf("v%0d_dataok", i), 32'(data_ok), 32'd1);
            chk($sformatf("v%0d_data", i), rdata_o, vecs[i].exp_data);
            chk($sformatf("v%0d_doneaddrok", i), 32'(addr_ok), 32'd0);
            chk($sformatf("v%0d_donecvalid", i), 32'(creq_valid), 32'd0);
            chk($sformatf("v%0d_donebusy", i), 32'(busy), 32'd1);
            exp_cnt = (exp_cnt + 1) % 4;
            cyc();
            #1;
            chk($sformatf("v%0d_dataok_off", i), 32'(data_ok), 32'd0);
            chk($sformatf("v%0d_busy_off", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_cnt", i), 32'(acc_count), 32'(exp_cnt));
        end

        // back-to-back: second request held valid through DONE
        present(32'h1FD0_0004, 3'd2, 4'b0000, 32'h0);
        #1;
        chk("b2b_a_addrok", 32'(addr_ok), 32'd1);
        cyc();
        present(32'h1FD0_0008, 3'd2, 4'b0000, 32'h0);
        cresp_ready = 1'b1; cresp_last = 1'b1; cresp_data = 32'h1111_2222;
        #1;
        chk("b2b_bus_addrok", 32'(addr_ok), 32'd0);
        chk("b2b_a_caddr", creq_addr, 32'h1FD0_0004);
        cyc();
        bus_idle();
        #1;
        chk("b2b_a_dataok", 32'(data_ok), 32'd1);
        chk("b2b_a_data", rdata_o, 32'h1111_2222);
        chk("b2b_done_addrok", 32'(addr_ok), 32'd0);
        exp_cnt = (exp_cnt + 1) % 4;
        cyc();
        #1;
        chk("b2b_b_addrok", 32'(addr_ok), 32'd1);
        chk("b2b_idle_dataok", 32'(data_ok), 32'd0);
        cyc();
        dreq_valid = 1'b0;
        cresp_ready = 1'b1; cresp_last = 1'b1; cresp_data = 32'h3333_4444;
        #1;
        chk("b2b_b_caddr", creq_addr, 32'h1FD0_0008);
        cyc();
        bus_idle();
        #1;
        chk("b2b_b_dataok", 32'(data_ok), 32'd1);
        chk("b2b_b_data", rdata_o, 32'h3333_4444);
        exp_cnt = (exp_cnt + 1) % 4;
        cyc();
        #1;
        chk("b2b_cnt", 32'(acc_count), 32'(exp_cnt));

        // cached requests are ignored
        dreq_valid = 1'b1; uncached = 1'b0; dreq_addr = 32'h8000_0000;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("cached%0d_addrok", c), 32'(addr_ok), 32'd0);
            chk($sformatf("cached%0d_cvalid", c), 32'(creq_valid), 32'd0);
            cyc();
        end

        // reset in the middle of BUS
        present(32'h1FD0_0020, 3'd2, 4'b0000, 32'h0);
        cyc();
        dreq_valid = 1'b0;
        #1;
        chk("rstmid_cvalid_pre", 32'(creq_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_cvalid", 32'(creq_valid), 32'd0);
        chk("rstmid_busy",   32'(busy), 32'd0);
        chk("rstmid_cnt",    32'(acc_count), 32'd0);
        exp_cnt = 0;
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rstmid%0d_dataok", c), 32'(data_ok), 32'd0);
            cyc();
        end

`ifdef UNCACHED_TIMEOUT_EN
        // watchdog abandon, then completion on the limit cycle
        for (int r = 0; r < 2; r++) begin
            present(32'h1FD0_0040, 3'd2, 4'b0000, 32'h0);
            cyc();
            dreq_valid = 1'b0;
            for (int w = 0; w < 8; w++) begin
                cresp_ready = (r == 1) && (w == 7);
                cresp_last  = (r == 1) && (w == 7);
                cresp_data  = 32'h5A5A_0008;
                #1;
                chk($sformatf("to%0d_bus%0d", r, w), 32'(creq_valid), 32'd1);
                cyc();
            end
            bus_idle();
            #1;
            chk($sformatf("to%0d_dataok", r), 32'(data_ok), 32'd1);
            chk($sformatf("to%0d_data", r), rdata_o, (r == 0) ? 32'hDEAD_BEEF : 32'h5A5A_0008);
            chk($sformatf("to%0d_err", r), 32'(timeout_err), (r == 0) ? 32'd1 : 32'd0);
            exp_cnt = (exp_cnt + 1) % 4;
            cyc();
            #1;
            chk($sformatf("to%0d_err_off", r), 32'(timeout_err), 32'd0);
            chk($sformatf("to%0d_cnt", r), 32'(acc_count), 32'(exp_cnt));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
